// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor
// Multi-cycle signed subtractor: op1 - op2 - b_in, LEVEL_W bits per clock,
// with the borrow chained between cycles through a single LEVEL_W-bit level.
// Start/busy/done handshake. Latency is WIDTH/LEVEL_W cycles from acceptance.
//
// Optional feature macro: SUB_ADD_MODE_EN
//   When defined, a `mode` input is added (sampled with the operands).
//   mode=1 computes op1 + op2 + b_in, where b_in is a carry in, b_out
//   reports carry out, and overflow is carry-into-MSB XOR carry-out.
//   When undefined, the block subtracts only.

module nibble_serial_subtractor #(
    parameter int WIDTH   = 16,
    parameter int LEVEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             b_in,
`ifdef SUB_ADD_MODE_EN
    input  logic             mode,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             b_out,
    output logic             overflow
);

    localparam int N     = WIDTH / LEVEL_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_reg;
    state_t              state_next;

    logic [IDX_W-1:0]    idx_reg;
    logic [WIDTH-1:0]    op1_reg;
    logic [WIDTH-1:0]    op2_reg;
    logic [WIDTH-1:0]    shadow_reg;
    logic [WIDTH-1:0]    shadow_next;
    logic [WIDTH-1:0]    result_reg;
    logic                b_out_reg;
    logic                overflow_reg;
    logic                done_reg;

    // The chain is always held as a true carry; in subtract mode this is the
    // inverted borrow, so the same adder serves both modes.
    logic                carry_reg;

    logic                accept;
    logic                last_nibble;
    logic                add_mode;
    logic                start_carry;

    logic [LEVEL_W-1:0]  op1_nib [N];
    logic [LEVEL_W-1:0]  op2_nib [N];
    logic [LEVEL_W-1:0]  a_nib;
    logic [LEVEL_W-1:0]  b_eff;
    logic [LEVEL_W:0]    sum;
    logic                carry_into_msb;

`ifdef SUB_ADD_MODE_EN
    logic                add_reg;

    // Capture the operation type together with the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_reg <= 1'b0;
        end else if (accept) begin
            add_reg <= mode;
        end
    end

    assign add_mode    = add_reg;
    // Subtract seeds the chain with the inverted borrow, add with the carry.
    assign start_carry = mode ? b_in : ~b_in;
`else
    assign add_mode    = 1'b0;
    assign start_carry = ~b_in;
`endif

    // Split the latched operands into nibble lanes and build the shadow
    // update: only the lane selected by the current index takes the new sum.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign op1_nib[gi] = op1_reg[gi*LEVEL_W +: LEVEL_W];
            assign op2_nib[gi] = op2_reg[gi*LEVEL_W +: LEVEL_W];
            assign shadow_next[gi*LEVEL_W +: LEVEL_W] =
                (idx_reg == IDX_W'(gi)) ? sum[LEVEL_W-1:0]
                                        : shadow_reg[gi*LEVEL_W +: LEVEL_W];
        end
    endgenerate

    // Single LEVEL_W-bit adder level shared by every nibble.
    assign a_nib = op1_nib[idx_reg];
    assign b_eff = add_mode ? op2_nib[idx_reg] : ~op2_nib[idx_reg];
    assign sum   = {1'b0, a_nib} + {1'b0, b_eff} + {{LEVEL_W{1'b0}}, carry_reg};

    // Carry entering the top bit of this nibble, recovered from the sum bit.
    assign carry_into_msb = sum[LEVEL_W-1] ^ a_nib[LEVEL_W-1] ^ b_eff[LEVEL_W-1];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        last_nibble = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (idx_reg == LAST_IDX) begin
                    last_nibble = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, nibble stepping and carry chaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_reg    <= '0;
            op2_reg    <= '0;
            shadow_reg <= '0;
            carry_reg  <= 1'b0;
            idx_reg    <= '0;
        end else if (accept) begin
            op1_reg    <= op1;
            op2_reg    <= op2;
            carry_reg  <= start_carry;
            idx_reg    <= '0;
        end else if (state_reg == RUN) begin
            shadow_reg <= shadow_next;
            carry_reg  <= sum[LEVEL_W];
            idx_reg    <= (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
        end
    end

    // Visible results change only on completion; done is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg   <= '0;
            b_out_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= last_nibble;
            if (last_nibble) begin
                result_reg   <= shadow_next;
                b_out_reg    <= add_mode ? sum[LEVEL_W] : ~sum[LEVEL_W];
                // Inverting both carries to borrows leaves the XOR unchanged.
                overflow_reg <= carry_into_msb ^ sum[LEVEL_W];
            end
        end
    end

    assign busy     = (state_reg == RUN);
    assign done     = done_reg;
    assign result   = result_reg;
    assign b_out    = b_out_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor
// Scoreboard bench: stimulus pushes expected results computed with plain
// integer arithmetic; a separate monitor pops on every done pulse.

module tb_nibble_serial_subtractor;

    localparam int WIDTH = 16;
    localparam int N     = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             b_in;
    logic             mode;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             b_out;
    logic             overflow;

    typedef struct {
        logic [WIDTH-1:0] r;
        logic             bo;
        logic             ov;
    } exp_t;

    exp_t exp_q[$];
    int   tests;
    int   fails;

    nibble_serial_subtractor #(.WIDTH(WIDTH), .LEVEL_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op1      (op1),
        .op2      (op2),
        .b_in     (b_in),
`ifdef SUB_ADD_MODE_EN
        .mode     (mode),
`endif
        .busy     (busy),
        .done     (done),
        .result   (result),
        .b_out    (b_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: the arithmetic meaning of the operation, not the nibble chain.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic bin, input logic md);
        exp_t e;
        int ua, ub, sa, sb, us, ss;
        ua = int'({16'h0, a});
        ub = int'({16'h0, b});
        sa = $signed(a);
        sb = $signed(b);
        if (md) begin
            us = ua + ub + int'(bin);
            ss = sa + sb + int'(bin);
            e.bo = (us > 65535);
        end else begin
            us = ua - ub - int'(bin);
            ss = sa - sb - int'(bin);
            e.bo = (us < 0);
        end
        e.r  = us[WIDTH-1:0];
        e.ov = (ss > 32767) || (ss < -32768);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got result 0x%0h, expected no completion", result);
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] done result=0x%04h b_out=%0b ovf=%0b (exp 0x%04h %0b %0b)",
                             result, b_out, overflow, e.r, e.bo, e.ov);
                    chk("result",   32'(result),   32'(e.r));
                    chk("b_out",    32'(b_out),    32'(e.bo));
                    chk("overflow", 32'(overflow), 32'(e.ov));
                end
            end
        end
    end

    // Issue one operation and wait for its completion. With b2b set the
    // caller is sitting in the done cycle of the previous operation.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic bin, input logic md, input bit b2b);
        int cnt;
        int guard;
        if (!b2b) @(negedge clk);
        guard = 0;
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("idle_before_start", 32'(busy), 32'd0);
        start = 1'b1;
        op1   = a;
        op2   = b;
        b_in  = bin;
        mode  = md;
        exp_q.push_back(model(a, b, bin, md));
        @(negedge clk);
        start = 1'b0;
        // Operand changes after acceptance must not matter.
        op1   = WIDTH'($urandom);
        op2   = WIDTH'($urandom);
        b_in  = 1'($urandom);
        mode  = 1'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        cnt = 0;
        while (cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (done) break;
        end
        chk("latency", 32'(cnt), 32'(N));
        chk("busy_at_done", 32'(busy), 32'd0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int cnt;
        logic [WIDTH-1:0] ra, rb;
        logic md;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op1   = '0;
        op2   = '0;
        b_in  = 1'b0;
        mode  = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset_busy",     32'(busy),     32'd0);
        chk("reset_done",     32'(done),     32'd0);
        chk("reset_result",   32'(result),   32'd0);
        chk("reset_b_out",    32'(b_out),    32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // Directed vectors.
        run_op(16'h1234, 16'h0234, 1'b0, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0005, 1'b1, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b0, 1'b1);   // accepted in done cycle
        run_op(16'hFFFF, 16'h7FFF, 1'b1, 1'b0, 1'b1);

        // Start while busy is ignored.
        @(negedge clk);
        start = 1'b1;
        op1   = 16'h0010;
        op2   = 16'h0001;
        b_in  = 1'b0;
        mode  = 1'b0;
        exp_q.push_back(model(16'h0010, 16'h0001, 1'b0, 1'b0));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        op1   = 16'hFFFF;
        op2   = 16'hFFFF;
        b_in  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!done && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("ignored_start_done_seen", 32'(done), 32'd1);
        chk("ignored_start_result", 32'(result), 32'h000F);
        repeat (6) @(negedge clk);   // a second done would be flagged by the monitor

        // Reset in the middle of an operation.
        start = 1'b1;
        op1   = 16'h00F0;
        op2   = 16'h0001;
        b_in  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",     32'(busy),     32'd0);
        chk("abort_done",     32'(done),     32'd0);
        chk("abort_result",   32'(result),   32'd0);
        chk("abort_b_out",    32'(b_out),    32'd0);
        chk("abort_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        run_op(16'h0003, 16'h0001, 1'b0, 1'b0, 1'b0);

`ifdef SUB_ADD_MODE_EN
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
`endif

        // Randomized operations, some back to back.
        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            if (i % 8 == 0) ra = 16'h8000;
            if (i % 8 == 1) rb = 16'h8000;
`ifdef SUB_ADD_MODE_EN
            md = 1'($urandom);
`else
            md = 1'b0;
`endif
            run_op(ra, rb, 1'($urandom), md, ($urandom_range(0, 1) == 1));
        end

        repeat (6) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
